// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: in-flight destination scoreboard,
// registered EX forwarding selects, load-use stall, branch flush and DMEM freeze.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  SYS_clk,
   input  logic                  SYS_reset_n,
   input  logic [REG_ADDR_W-1:0] D_rs,
   input  logic [REG_ADDR_W-1:0] D_rt,
   input  logic                  D_use_rs,
   input  logic                  D_use_rt,
   input  logic [REG_ADDR_W-1:0] D_write_register,
   input  logic                  D_RegWrite,
   input  logic                  D_MemRead,
   input  logic                  EX_branch_taken,
   input  logic                  MEM_access,
   input  logic                  DMEM_ready,
   output logic                  PC_en,
   output logic                  D_en,
   output logic                  D_flush,
   output logic                  EX_bubble,
   output logic                  pipe_en,
   output logic [1:0]            EX_fwd_a,
   output logic [1:0]            EX_fwd_b,
   output logic [1:0]            HZ_state,
   output logic [CNT_W-1:0]      HZ_stall_cycles
);

   typedef struct packed {
      logic                  wr;
      logic [REG_ADDR_W-1:0] rd;
      logic                  ld;
   } sb_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LU_STALL = 2'b01,
      FLUSH    = 2'b10,
      MEM_WAIT = 2'b11
   } hz_state_e;

   // The WB entry is not kept: the regfile writes before it reads, so nothing would consume it.
   sb_t              sb_ex_q, sb_ex_d, sb_mem_q;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             mw, lu;
   logic             pc_en_c, d_en_c, d_flush_c, bubble_c, pipe_en_c;

   function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_ADDR_W-1:0] r,
                                          input sb_t ex, input sb_t mem);
      if (use_r && ex.wr && r == ex.rd && !ex.ld) return 2'b10;
      else if (use_r && mem.wr && r == mem.rd)    return 2'b01;
      else                                        return 2'b00;
   endfunction

   assign mw = MEM_access & ~DMEM_ready;
   assign lu = sb_ex_q.wr & sb_ex_q.ld &
               ((D_use_rs & (D_rs == sb_ex_q.rd)) | (D_use_rt & (D_rt == sb_ex_q.rd)));

   always_comb begin
      pc_en_c   = 1'b1;
      d_en_c    = 1'b1;
      d_flush_c = 1'b0;
      bubble_c  = 1'b0;
      pipe_en_c = 1'b1;
      state_d   = RUN;
      if (!SYS_reset_n) begin
         pc_en_c   = 1'b0;
         d_en_c    = 1'b0;
         pipe_en_c = 1'b0;
      end else if (mw) begin
         pc_en_c   = 1'b0;
         d_en_c    = 1'b0;
         pipe_en_c = 1'b0;
         state_d   = MEM_WAIT;
      end else if (EX_branch_taken) begin
         d_flush_c = 1'b1;
         bubble_c  = 1'b1;
         state_d   = FLUSH;
      end else if (lu) begin
         pc_en_c   = 1'b0;
         d_en_c    = 1'b0;
         bubble_c  = 1'b1;
         state_d   = LU_STALL;
      end
   end

   always_comb begin
      sb_ex_d = '0;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (!bubble_c) begin
         sb_ex_d.wr = D_RegWrite & (D_write_register != '0);
         sb_ex_d.rd = D_write_register;
         sb_ex_d.ld = D_MemRead;
         fwd_a_d    = fwd_sel(D_use_rs, D_rs, sb_ex_q, sb_mem_q);
         fwd_b_d    = fwd_sel(D_use_rt, D_rt, sb_ex_q, sb_mem_q);
      end
   end

   always_ff @(posedge SYS_clk) begin
      if (!SYS_reset_n) begin
         sb_ex_q  <= '0;
         sb_mem_q <= '0;
         fwd_a_q  <= 2'b00;
         fwd_b_q  <= 2'b00;
         state_q  <= RUN;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (pipe_en_c) begin
            sb_mem_q <= sb_ex_q;
            sb_ex_q  <= sb_ex_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
         end
         if (!pc_en_c && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign PC_en           = pc_en_c;
   assign D_en            = d_en_c;
   assign D_flush         = d_flush_c;
   assign EX_bubble       = bubble_c;
   assign pipe_en         = pipe_en_c;
   assign EX_fwd_a        = fwd_a_q;
   assign EX_fwd_b        = fwd_b_q;
   assign HZ_state        = state_q;
   assign HZ_stall_cycles = cnt_q;

endmodule
